// File: rtl/snake_game_ctrl.sv
// Snake game sequencing controller: game FSM, movement tick, direction filter, apple handshake.
// Optional macro SNAKE_SPEEDUP_EN shortens the tick period on every placed apple.
module snake_game_ctrl #(
    parameter int unsigned TICK_DIV  = 25000000,
    parameter logic [7:0]  WIN_LEN   = 8'd50,
    parameter int unsigned TICK_STEP = 1000000,
    parameter int unsigned TICK_MIN  = 5000000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Btn_Up,
    input  logic        Btn_Down,
    input  logic        Btn_Left,
    input  logic        Btn_Right,
    input  logic [7:0]  Length,
    input  logic        Collision,
    input  logic        Apple_Eaten,
    input  logic        Apple_Ack,
    output logic        q_I,
    output logic        q_Run,
    output logic        q_Win,
    output logic        q_Lose,
    output logic        Speed_Clk,
    output logic [1:0]  In_Dirn,
    output logic        SCEN,
    output logic        Apple_Req,
    output logic [31:0] Tick_Period
);

    // A period below 2 cycles cannot produce a single-cycle tick; a zero step is a config error.
    if (TICK_DIV < 2 || TICK_MIN < 2 || TICK_STEP == 0) begin : g_bad_cfg
        $error("snake_game_ctrl: illegal tick configuration");
    end

    // One-hot encoding so the state outputs come straight from flops.
    typedef enum logic [3:0] {
        S_INIT = 4'b0001,
        S_RUN  = 4'b0010,
        S_WIN  = 4'b0100,
        S_LOSE = 4'b1000
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] period_q, period_d;
    logic        speed_q, speed_d;
    logic [1:0]  dirn_q, dirn_d;
    logic        scen_q, scen_d;
    logic        req_q, req_d;
    logic        lock_q, lock_d;

    logic        btn_any;
    logic [1:0]  btn_dir;
    logic        tick_due;

    assign btn_any  = Btn_Up | Btn_Down | Btn_Left | Btn_Right;
    assign btn_dir  = Btn_Up ? 2'b00 : Btn_Down ? 2'b01 : Btn_Left ? 2'b10 : 2'b11;
    // >= rather than == so a freshly shortened period fires on the next advancing cycle.
    assign tick_due = cnt_q >= (period_q - 32'd1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        speed_d  = 1'b0;
        dirn_d   = dirn_q;
        scen_d   = 1'b0;
        req_d    = req_q;
        lock_d   = lock_q;

        unique case (state_q)
            S_INIT: begin
                cnt_d = '0;
                if (Start) begin
                    state_d  = S_RUN;
                    dirn_d   = 2'b00;
                    req_d    = 1'b0;
                    period_d = TICK_DIV;
                    lock_d   = 1'b0;
                end
            end
            S_RUN: begin
                if (Collision) begin
                    state_d = S_LOSE;
                    req_d   = 1'b0;
                end else if (Length >= WIN_LEN) begin
                    state_d = S_WIN;
                    req_d   = 1'b0;
                end else begin
                    if (!req_q) begin
                        if (tick_due) begin
                            cnt_d   = '0;
                            speed_d = 1'b1;
                            lock_d  = 1'b0;
                        end else begin
                            cnt_d = cnt_q + 32'd1;
                        end
                    end
                    // Same axis as the current heading means equal or reverse: both rejected.
                    if (btn_any && !lock_q && (btn_dir[1] != dirn_q[1])) begin
                        dirn_d = btn_dir;
                        scen_d = 1'b1;
                        lock_d = 1'b1;
                    end
                    if (req_q) begin
                        if (Apple_Ack) begin
                            req_d = 1'b0;
`ifdef SNAKE_SPEEDUP_EN
                            if ({1'b0, period_q} >= (33'(TICK_MIN) + 33'(TICK_STEP)))
                                period_d = period_q - TICK_STEP;
                            else
                                period_d = TICK_MIN;
`endif
                        end
                    end else if (Apple_Eaten) begin
                        req_d = 1'b1;
                    end
                end
            end
            S_WIN, S_LOSE: begin
                if (Start) begin
                    state_d = S_INIT;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_INIT;
            cnt_q    <= '0;
            period_q <= TICK_DIV;
            speed_q  <= 1'b0;
            dirn_q   <= 2'b00;
            scen_q   <= 1'b0;
            req_q    <= 1'b0;
            lock_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            speed_q  <= speed_d;
            dirn_q   <= dirn_d;
            scen_q   <= scen_d;
            req_q    <= req_d;
            lock_q   <= lock_d;
        end
    end

    assign q_I         = state_q[0];
    assign q_Run       = state_q[1];
    assign q_Win       = state_q[2];
    assign q_Lose      = state_q[3];
    assign Speed_Clk   = speed_q;
    assign In_Dirn     = dirn_q;
    assign SCEN        = scen_q;
    assign Apple_Req   = req_q;
    assign Tick_Period = period_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Bench for snake_game_ctrl: directed scenarios with literal expectations plus random play
// checked every cycle against a behavioural game model.
module tb_snake_game_ctrl;
`ifdef SNAKE_SPEEDUP_EN
    localparam int TD = 10;
    localparam int P1 = 7;
    localparam int P2 = 5;
`else
    localparam int TD = 4;
    localparam int P1 = 4;
    localparam int P2 = 4;
`endif
    localparam int TS = 3;
    localparam int TM = 5;
    localparam int WL = 50;

    logic        Clk = 0, Reset = 1, Start = 0;
    logic        Btn_Up = 0, Btn_Down = 0, Btn_Left = 0, Btn_Right = 0;
    logic [7:0]  Length = 0;
    logic        Collision = 0, Apple_Eaten = 0, Apple_Ack = 0;
    logic        q_I, q_Run, q_Win, q_Lose, Speed_Clk, SCEN, Apple_Req;
    logic [1:0]  In_Dirn;
    logic [31:0] Tick_Period;

    int total = 0;
    int bad = 0;

    always #5 Clk = ~Clk;

    snake_game_ctrl #(.TICK_DIV(TD), .WIN_LEN(8'(WL)), .TICK_STEP(TS), .TICK_MIN(TM)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start),
        .Btn_Up(Btn_Up), .Btn_Down(Btn_Down), .Btn_Left(Btn_Left), .Btn_Right(Btn_Right),
        .Length(Length), .Collision(Collision), .Apple_Eaten(Apple_Eaten), .Apple_Ack(Apple_Ack),
        .q_I(q_I), .q_Run(q_Run), .q_Win(q_Win), .q_Lose(q_Lose),
        .Speed_Clk(Speed_Clk), .In_Dirn(In_Dirn), .SCEN(SCEN),
        .Apple_Req(Apple_Req), .Tick_Period(Tick_Period)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: game phase 0=init 1=run 2=win 3=lose; outputs as they appear after the edge.
    int         m_st, m_cnt, m_per;
    logic       m_spd, m_scen, m_req, m_lock;
    logic [1:0] m_dir;

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_per = TD;
        m_spd = 0; m_scen = 0; m_req = 0; m_lock = 0; m_dir = 2'b00;
    endtask

    task automatic model_step();
        bit         was_locked;
        bit         any;
        logic [1:0] want;
        logic [1:0] rev;
        int         np;
        if (Reset) begin
            model_reset();
            return;
        end
        m_spd = 0;
        m_scen = 0;
        case (m_st)
            0: begin
                m_cnt = 0;
                if (Start) begin
                    m_st = 1; m_dir = 2'b00; m_req = 0; m_per = TD; m_lock = 0;
                end
            end
            1: begin
                if (Collision) begin
                    m_st = 3; m_req = 0;
                end else if (int'(Length) >= WL) begin
                    m_st = 2; m_req = 0;
                end else begin
                    was_locked = m_lock;
                    if (!m_req) begin
                        m_cnt++;
                        if (m_cnt >= m_per) begin
                            m_cnt = 0; m_spd = 1; m_lock = 0;
                        end
                    end
                    any = Btn_Up | Btn_Down | Btn_Left | Btn_Right;
                    if (Btn_Up) want = 2'b00;
                    else if (Btn_Down) want = 2'b01;
                    else if (Btn_Left) want = 2'b10;
                    else want = 2'b11;
                    rev = {m_dir[1], ~m_dir[0]};
                    if (any && !was_locked && want != m_dir && want != rev) begin
                        m_dir = want; m_scen = 1; m_lock = 1;
                    end
                    if (m_req && Apple_Ack) begin
                        m_req = 0;
`ifdef SNAKE_SPEEDUP_EN
                        np = m_per - TS;
                        if (np < TM) np = TM;
                        m_per = np;
`else
                        np = 0;
`endif
                    end else if (!m_req && Apple_Eaten) begin
                        m_req = 1;
                    end
                end
            end
            default: begin
                if (Start) begin
                    m_st = 0; m_cnt = 0;
                end
            end
        endcase
    endtask

    // Compare process: inputs are stable at the falling edge and are what the next rising edge samples.
    initial begin
        model_reset();
        forever begin
            @(negedge Clk);
            if (Reset) model_reset();
            chk("cmp_q_I", q_I, m_st == 0);
            chk("cmp_q_Run", q_Run, m_st == 1);
            chk("cmp_q_Win", q_Win, m_st == 2);
            chk("cmp_q_Lose", q_Lose, m_st == 3);
            chk("cmp_Speed_Clk", Speed_Clk, m_spd);
            chk("cmp_In_Dirn", In_Dirn, m_dir);
            chk("cmp_SCEN", SCEN, m_scen);
            chk("cmp_Apple_Req", Apple_Req, m_req);
            chk("cmp_Tick_Period", Tick_Period, m_per);
            model_step();
        end
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
        Start = 0; Btn_Up = 0; Btn_Down = 0; Btn_Left = 0; Btn_Right = 0;
        Apple_Eaten = 0; Apple_Ack = 0;
    endtask

    task automatic wait_tick();
        for (int i = 0; i < 4 * TD + 4; i++) begin
            cyc();
            if (Speed_Clk) return;
        end
        chk("tick_timeout", 0, 1);
    endtask

    int pulses;

    initial begin
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Reset = 0;
        chk("rst_q_I", q_I, 1);
        chk("rst_q_Run", q_Run, 0);
        chk("rst_period", Tick_Period, TD);
        chk("rst_dirn", In_Dirn, 0);
        pulses = 0;
        for (int i = 0; i < 2 * TD; i++) begin cyc(); pulses += Speed_Clk; end
        chk("init_no_tick", pulses, 0);

        // start and tick cadence
        Start = 1; cyc();
        chk("start_run", q_Run, 1);
        pulses = 0;
        for (int i = 0; i < 3 * TD; i++) begin cyc(); pulses += Speed_Clk; end
        chk("tick_count", pulses, 3);
        Reset = 1; cyc(); Reset = 0;
        chk("midrun_reset_I", q_I, 1);
        pulses = 0;
        for (int i = 0; i < 2 * TD; i++) begin cyc(); pulses += Speed_Clk; end
        chk("after_reset_no_tick", pulses, 0);

        // direction filter
        Start = 1; cyc();
        Btn_Down = 1; cyc();
        chk("reverse_rej_scen", SCEN, 0);
        chk("reverse_rej_dirn", In_Dirn, 0);
        Btn_Left = 1; cyc();
        chk("left_dirn", In_Dirn, 2);
        chk("left_scen", SCEN, 1);
        cyc();
        chk("scen_one_cycle", SCEN, 0);
        Btn_Right = 1; cyc();
        chk("right_locked_dirn", In_Dirn, 2);
        wait_tick();
        Btn_Up = 1; cyc();
        chk("up_after_tick", In_Dirn, 0);
        chk("up_scen", SCEN, 1);
        Btn_Left = 1; cyc();
        chk("lock_holds", In_Dirn, 0);
        wait_tick();
        Btn_Right = 1; cyc();
        chk("right_dirn", In_Dirn, 3);
        wait_tick();
        Btn_Up = 1; Btn_Left = 1; cyc();
        chk("priority_up", In_Dirn, 0);

        // apple handshake freezes the tick counter
        wait_tick();
        cyc();
        Apple_Eaten = 1; cyc();
        chk("req_set", Apple_Req, 1);
        pulses = 0;
        for (int i = 0; i < 9; i++) begin cyc(); pulses += Speed_Clk; end
        chk("frozen_no_tick", pulses, 0);
        chk("req_held", Apple_Req, 1);
        Apple_Ack = 1; cyc();
        chk("req_clear", Apple_Req, 0);
        chk("period_1", Tick_Period, P1);
        pulses = 0;
        for (int i = 0; i < P1 - 3; i++) begin cyc(); pulses += Speed_Clk; end
        chk("resume_wait", pulses, 0);
        cyc();
        chk("resume_tick", Speed_Clk, 1);
        Apple_Eaten = 1; cyc();
        Apple_Ack = 1; cyc();
        chk("period_2", Tick_Period, P2);
        Apple_Eaten = 1; cyc();
        Apple_Ack = 1; cyc();
        chk("period_3", Tick_Period, P2);

        // win/lose resolution
        Length = 8'd50; Collision = 1; cyc();
        chk("lose_priority", q_Lose, 1);
        chk("not_win", q_Win, 0);
        Length = 0; Collision = 0;
        Start = 1; cyc();
        chk("lose_to_init", q_I, 1);
        Start = 1; cyc();
        Length = 8'd50; cyc();
        chk("win", q_Win, 1);
        Length = 0;
        Start = 1; cyc();
        chk("win_to_init", q_I, 1);

        // random play
        for (int i = 0; i < 3000; i++) begin
            Reset       = ($urandom_range(399) == 0);
            Start       = ($urandom_range(24) == 0);
            Btn_Up      = ($urandom_range(7) == 0);
            Btn_Down    = ($urandom_range(7) == 0);
            Btn_Left    = ($urandom_range(7) == 0);
            Btn_Right   = ($urandom_range(7) == 0);
            Apple_Eaten = ($urandom_range(9) == 0);
            Apple_Ack   = ($urandom_range(5) == 0);
            Collision   = ($urandom_range(149) == 0);
            Length      = ($urandom_range(99) == 0) ? 8'($urandom_range(255, 50))
                                                    : 8'($urandom_range(49));
            @(posedge Clk); #1;
        end
        Reset = 0;
        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/snake_game_ctrl.md
Name: snake_game_ctrl

Overview:
Top-level sequencing controller for the Snake datapath. Owns the game FSM (Init/Run/Win/Lose) and generates the single-cycle movement tick (Speed_Clk). Filters direction buttons into a legal In_Dirn/SCEN strobe and runs the apple-respawn request/acknowledge handshake with the apple generator. Sits between the debounced button/switch logic and the length/apple datapath modules.

Parameters:
TICK_DIV, 25000000, Clk cycles per movement tick (must be >= 2)
WIN_LEN, 8'd50, snake Length at which the game is won
TICK_STEP, 1000000, period reduction per apple eaten (used only with SNAKE_SPEEDUP_EN)
TICK_MIN, 5000000, minimum tick period (used only with SNAKE_SPEEDUP_EN)

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
Start  in  1  debounced single-cycle pulse; start/restart
Btn_Up, Btn_Down, Btn_Left, Btn_Right  in  1 each  debounced single-cycle direction pulses
Length  in  8  current snake length from the length datapath
Collision  in  1  level, wall/body hit from the length datapath
Apple_Eaten  in  1  single-cycle pulse: head landed on apple
Apple_Ack  in  1  single-cycle pulse: apple generator placed a new apple
q_I, q_Run, q_Win, q_Lose  out  1 each  one-hot state outputs
Speed_Clk  out  1  single-cycle movement tick
In_Dirn  out  2  committed direction: 00 up, 01 down, 10 left, 11 right
SCEN  out  1  single-cycle strobe, In_Dirn changed this cycle
Apple_Req  out  1  level, new apple requested
Tick_Period  out  32  current tick period in Clk cycles

Behaviour:
- Reset (async, any time, including mid-game): state INIT; q_I=1, others 0; Speed_Clk=0, SCEN=0, In_Dirn=00, Apple_Req=0, tick counter=0, Tick_Period=TICK_DIV, turn lock cleared.
- All outputs registered; each reacts one Clk after the causing input.
- FSM: INIT -> RUN on Start. RUN -> LOSE when Collision=1. RUN -> WIN when Length >= WIN_LEN and Collision=0; Collision takes priority when both hold. WIN/LOSE -> INIT on Start. Start is ignored in RUN.
- Entering RUN: tick counter=0, In_Dirn=00, Apple_Req=0, Tick_Period=TICK_DIV.
- Tick counter advances only in RUN with Apple_Req=0, holding otherwise. When counter==Tick_Period-1: Speed_Clk=1 next cycle and counter wraps to 0. Speed_Clk is never asserted outside RUN. In INIT the counter is held at 0.
- Direction filter, RUN only:
  - Simultaneous buttons resolve by priority Up > Down > Left > Right.
  - The request is rejected if it is the reverse of In_Dirn (bit1 equal, bit0 different) or equal to In_Dirn.
  - An accepted request updates In_Dirn and pulses SCEN for 1 cycle, then sets the turn lock.
  - The turn lock blocks further changes until the next Speed_Clk, which clears it. At most one turn per tick.
  - Buttons are ignored outside RUN.
- Apple handshake:
  - Apple_Eaten in RUN sets Apple_Req=1 next cycle. Apple_Req holds until Apple_Ack, then clears the following cycle.
  - Apple_Ack with Apple_Req=0 is ignored.
  - Apple_Eaten while Apple_Req=1 is ignored (no queueing).
  - Apple_Req is forced to 0 on leaving RUN.
- Tick_Period is constant TICK_DIV unless the optional feature is compiled in.

Optional Feature:
SNAKE_SPEEDUP_EN:
- Defined: on each accepted Apple_Ack, Tick_Period = max(Tick_Period - TICK_STEP, TICK_MIN), with saturating subtraction and no underflow. If the counter is already >= the new period-1, Speed_Clk fires on the next advancing cycle and the counter wraps. Period resets to TICK_DIV on entering RUN.
- Undefined: Tick_Period is fixed at TICK_DIV; Apple_Ack affects only Apple_Req.

Test Plan:
1. TICK_DIV=4: Reset, Start pulse -> q_Run=1 next cycle; Speed_Clk pulses once every 4 cycles; none in INIT; none after Reset is asserted mid-run.
2. RUN, In_Dirn=00: Btn_Down -> rejected, SCEN=0. Then Btn_Left -> In_Dirn=10, SCEN 1 cycle. Then Btn_Right before the next tick -> ignored (lock and reverse). After the tick, Btn_Up -> In_Dirn=00.
3. Btn_Up and Btn_Left in the same cycle with In_Dirn=11 -> In_Dirn=00.
4. Apple_Eaten pulse -> Apple_Req=1 and Speed_Clk frozen, counter held. Apple_Ack 10 cycles later -> Apple_Req=0 and ticks resume from the held count.
5. Length=50 with Collision=1 in the same cycle -> q_Lose=1, not q_Win. Separately, Length=50 alone -> q_Win. Start from WIN -> q_I.
6. SNAKE_SPEEDUP_EN, TICK_DIV=10, TICK_STEP=3, TICK_MIN=5: three Apple_Ack -> Tick_Period 7, then 5, then 5.
